// File: rtl/mem_arbiter_if.sv
// Bundles the two cache ports and the shared memory port of mem_arbiter.
// master = requesters/memory model side, slave = arbiter side.
interface mem_arbiter_if;
    logic        i_p0_ren;
    logic        i_p0_wen;
    logic [31:0] i_p0_addr;
    logic [31:0] i_p0_wdata;
    logic        o_p0_ready;
    logic        o_p0_valid;
    logic [31:0] o_p0_rdata;

    logic        i_p1_ren;
    logic        i_p1_wen;
    logic [31:0] i_p1_addr;
    logic [31:0] i_p1_wdata;
    logic        o_p1_ready;
    logic        o_p1_valid;
    logic [31:0] o_p1_rdata;

    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;
    logic        i_mem_valid;

    logic [1:0]  o_grant;

    modport master (
        output i_p0_ren, i_p0_wen, i_p0_addr, i_p0_wdata,
        input  o_p0_ready, o_p0_valid, o_p0_rdata,
        output i_p1_ren, i_p1_wen, i_p1_addr, i_p1_wdata,
        input  o_p1_ready, o_p1_valid, o_p1_rdata,
        input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
        output i_mem_ready, i_mem_rdata, i_mem_valid,
        input  o_grant
    );

    modport slave (
        input  i_p0_ren, i_p0_wen, i_p0_addr, i_p0_wdata,
        output o_p0_ready, o_p0_valid, o_p0_rdata,
        input  i_p1_ren, i_p1_wen, i_p1_addr, i_p1_wdata,
        output o_p1_ready, o_p1_valid, o_p1_rdata,
        output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
        input  i_mem_ready, i_mem_rdata, i_mem_valid,
        output o_grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: owner keeps the bus until it idles and its outstanding reads drain.
// `define MEM_ARBITER_FIXED_PRIO_EN makes port 1 win every IDLE tie; default is round-robin.
module mem_arbiter #(
    parameter int MAX_OUT = 4
) (
    input logic           i_clk,
    input logic           i_rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        owner, owner_nxt;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
`else
    logic        rr_last, rr_nxt;
`endif

    logic        cur, own, req0, req1, tie_pick, pick;
    logic        sel_ren, sel_wen, accept, rd_accept, rsp;
    logic [31:0] sel_addr, sel_wdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt   <= '0;
            owner <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
        end
    end

`ifdef MEM_ARBITER_FIXED_PRIO_EN
`else
    // Reset value 0 means "port 0 granted last", so port 1 takes the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rr_last <= 1'b0;
        else          rr_last <= rr_nxt;
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        owner_nxt = owner;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        tie_pick  = 1'b1;
`else
        rr_nxt    = rr_last;
        tie_pick  = ~rr_last;
`endif

        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_ren   = 1'b0;
        bus.o_mem_wen   = 1'b0;
        bus.o_grant     = 2'b00;

        req0 = bus.i_p0_ren | bus.i_p0_wen;
        req1 = bus.i_p1_ren | bus.i_p1_wen;
        pick = (req0 && req1) ? tie_pick : req1;

        // DRAIN keeps steering returns to the port that issued the reads.
        cur = (state == OWN1) || ((state == DRAIN) && owner);
        own = (state == OWN0) || (state == OWN1);

        sel_ren   = cur ? bus.i_p1_ren   : bus.i_p0_ren;
        sel_wen   = cur ? bus.i_p1_wen   : bus.i_p0_wen;
        sel_addr  = cur ? bus.i_p1_addr  : bus.i_p0_addr;
        sel_wdata = cur ? bus.i_p1_wdata : bus.i_p0_wdata;

        if (own) begin
            bus.o_mem_addr  = sel_addr;
            bus.o_mem_wdata = sel_wdata;
            bus.o_mem_wen   = sel_wen;
            // Write wins over an illegal ren+wen; reads stall once MAX_OUT are in flight.
            bus.o_mem_ren   = sel_ren & ~sel_wen & (cnt < MAX_CNT);
        end

        accept    = (bus.o_mem_ren | bus.o_mem_wen) & bus.i_mem_ready;
        rd_accept = accept & bus.o_mem_ren;
        // A return with nothing outstanding is stale (e.g. issued before reset) and dropped.
        rsp       = bus.i_mem_valid && (cnt != 3'd0) && (state != IDLE);

        bus.o_p0_ready = accept & ~cur;
        bus.o_p1_ready = accept &  cur;
        bus.o_p0_valid = rsp & ~cur;
        bus.o_p1_valid = rsp &  cur;
        bus.o_p0_rdata = (rsp & ~cur) ? bus.i_mem_rdata : '0;
        bus.o_p1_rdata = (rsp &  cur) ? bus.i_mem_rdata : '0;

        if (state != IDLE) bus.o_grant = cur ? 2'b10 : 2'b01;

        if (rd_accept && !rsp)      cnt_nxt = cnt + 3'd1;
        else if (rsp && !rd_accept) cnt_nxt = cnt - 3'd1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = pick ? OWN1 : OWN0;
                    owner_nxt = pick;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
`else
                    rr_nxt    = pick;
`endif
                end
            end
            OWN0, OWN1: begin
                if (!(sel_ren || sel_wen)) state_nxt = (cnt_nxt == 3'd0) ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (cnt_nxt == 3'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter (MAX_OUT = 4) plus hand sequences for ties and reset.
module tb_mem_arbiter;

    typedef struct packed {
        logic        p0_ren;
        logic        p0_wen;
        logic [31:0] p0_addr;
        logic [31:0] p0_wdata;
        logic        p1_ren;
        logic        p1_wen;
        logic [31:0] p1_addr;
        logic [31:0] p1_wdata;
        logic        mem_ready;
        logic        mem_valid;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic [1:0]  grant;
        logic        mem_ren;
        logic        mem_wen;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        p0_ready;
        logic        p0_valid;
        logic [31:0] p0_rdata;
        logic        p1_ready;
        logic        p1_valid;
        logic [31:0] p1_rdata;
        logic [2:0]  cnt;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    row_t tbl[32];

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_OUT(4)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic in_t ii(input logic p0r, input logic p0w, input logic [31:0] a0,
                               input logic [31:0] d0, input logic p1r, input logic p1w,
                               input logic [31:0] a1, input logic rdy, input logic vld,
                               input logic [31:0] rd);
        in_t v;
        v.p0_ren = p0r; v.p0_wen = p0w; v.p0_addr = a0; v.p0_wdata = d0;
        v.p1_ren = p1r; v.p1_wen = p1w; v.p1_addr = a1; v.p1_wdata = 32'h0;
        v.mem_ready = rdy; v.mem_valid = vld; v.mem_rdata = rd;
        return v;
    endfunction

    function automatic out_t oo(input logic [1:0] g, input logic mr, input logic mw,
                                input logic [31:0] ma, input logic [31:0] md,
                                input logic r0, input logic v0, input logic r1, input logic v1,
                                input logic [31:0] rd, input logic [2:0] c);
        out_t o;
        o.grant = g; o.mem_ren = mr; o.mem_wen = mw; o.mem_addr = ma; o.mem_wdata = md;
        o.p0_ready = r0; o.p0_valid = v0; o.p0_rdata = v0 ? rd : 32'h0;
        o.p1_ready = r1; o.p1_valid = v1; o.p1_rdata = v1 ? rd : 32'h0;
        o.cnt = c;
        return o;
    endfunction

    function automatic out_t zo();
        return oo(2'b00, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 3'd0);
    endfunction

    function automatic in_t idle_in(input logic vld, input logic [31:0] rd);
        return ii(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1, vld, rd);
    endfunction

    task automatic drive(input in_t v);
        bus.i_p0_ren = v.p0_ren;   bus.i_p0_wen = v.p0_wen;
        bus.i_p0_addr = v.p0_addr; bus.i_p0_wdata = v.p0_wdata;
        bus.i_p1_ren = v.p1_ren;   bus.i_p1_wen = v.p1_wen;
        bus.i_p1_addr = v.p1_addr; bus.i_p1_wdata = v.p1_wdata;
        bus.i_mem_ready = v.mem_ready; bus.i_mem_valid = v.mem_valid;
        bus.i_mem_rdata = v.mem_rdata;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act.grant = bus.o_grant; act.mem_ren = bus.o_mem_ren; act.mem_wen = bus.o_mem_wen;
        act.mem_addr = bus.o_mem_addr; act.mem_wdata = bus.o_mem_wdata;
        act.p0_ready = bus.o_p0_ready; act.p0_valid = bus.o_p0_valid; act.p0_rdata = bus.o_p0_rdata;
        act.p1_ready = bus.o_p1_ready; act.p1_valid = bus.o_p1_valid; act.p1_rdata = bus.o_p1_rdata;
        act.cnt = dut.cnt;
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic apply(input string name, input in_t v, input out_t exp);
        @(negedge clk);
        drive(v);
        #2;
        check(name, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(idle_in(0, 32'h0));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Single port read, write with ready held low, MAX_OUT stall, drain handover, stray return, ren+wen.
        tbl[0]  = '{ii(1,0,32'h100,0, 0,0,0, 1,0,0), zo()};
        tbl[1]  = '{ii(1,0,32'h100,0, 0,0,0, 1,0,0), oo(2'b01,1,0,32'h100,0, 1,0,0,0,0, 0)};
        tbl[2]  = '{idle_in(1,32'h11111111),         oo(2'b01,0,0,0,0, 0,1,0,0,32'h11111111, 1)};
        tbl[3]  = '{ii(0,1,32'h40,32'hDEADBEEF, 0,0,0, 0,0,0), zo()};
        tbl[4]  = '{ii(0,1,32'h40,32'hDEADBEEF, 0,0,0, 0,0,0), oo(2'b01,0,1,32'h40,32'hDEADBEEF, 0,0,0,0,0, 0)};
        tbl[5]  = '{ii(0,1,32'h40,32'hDEADBEEF, 0,0,0, 0,0,0), oo(2'b01,0,1,32'h40,32'hDEADBEEF, 0,0,0,0,0, 0)};
        tbl[6]  = '{ii(0,1,32'h40,32'hDEADBEEF, 0,0,0, 0,0,0), oo(2'b01,0,1,32'h40,32'hDEADBEEF, 0,0,0,0,0, 0)};
        tbl[7]  = '{ii(0,1,32'h40,32'hDEADBEEF, 0,0,0, 1,0,0), oo(2'b01,0,1,32'h40,32'hDEADBEEF, 1,0,0,0,0, 0)};
        tbl[8]  = '{idle_in(0,0),                    oo(2'b01,0,0,0,0, 0,0,0,0,0, 0)};
        tbl[9]  = '{ii(0,0,0,0, 1,0,32'h200, 1,0,0), zo()};
        tbl[10] = '{ii(0,0,0,0, 1,0,32'h200, 1,0,0), oo(2'b10,1,0,32'h200,0, 0,0,1,0,0, 0)};
        tbl[11] = '{ii(0,0,0,0, 1,0,32'h204, 1,0,0), oo(2'b10,1,0,32'h204,0, 0,0,1,0,0, 1)};
        tbl[12] = '{ii(0,0,0,0, 1,0,32'h208, 1,0,0), oo(2'b10,1,0,32'h208,0, 0,0,1,0,0, 2)};
        tbl[13] = '{ii(0,0,0,0, 1,0,32'h20C, 1,0,0), oo(2'b10,1,0,32'h20C,0, 0,0,1,0,0, 3)};
        tbl[14] = '{ii(0,0,0,0, 1,0,32'h210, 1,0,0), oo(2'b10,0,0,32'h210,0, 0,0,0,0,0, 4)};
        tbl[15] = '{ii(0,0,0,0, 1,0,32'h210, 1,1,32'hA0A0A0A0), oo(2'b10,0,0,32'h210,0, 0,0,0,1,32'hA0A0A0A0, 4)};
        tbl[16] = '{ii(0,0,0,0, 1,0,32'h210, 1,0,0), oo(2'b10,1,0,32'h210,0, 0,0,1,0,0, 3)};
        tbl[17] = '{ii(0,0,0,0, 1,0,32'h214, 1,1,32'hB1B1B1B1), oo(2'b10,0,0,32'h214,0, 0,0,0,1,32'hB1B1B1B1, 4)};
        tbl[18] = '{ii(0,0,0,0, 1,0,32'h214, 1,1,32'hC0C0C0C0), oo(2'b10,1,0,32'h214,0, 0,0,1,1,32'hC0C0C0C0, 3)};
        tbl[19] = '{ii(0,0,0,0, 1,0,32'h218, 0,1,32'hC1C1C1C1), oo(2'b10,1,0,32'h218,0, 0,0,0,1,32'hC1C1C1C1, 3)};
        tbl[20] = '{ii(1,0,32'h300,0, 0,0,0, 1,0,0), oo(2'b10,0,0,0,0, 0,0,0,0,0, 2)};
        tbl[21] = '{ii(1,0,32'h300,0, 0,0,0, 1,0,0), oo(2'b10,0,0,0,0, 0,0,0,0,0, 2)};
        tbl[22] = '{ii(1,0,32'h300,0, 0,0,0, 1,1,32'hC2C2C2C2), oo(2'b10,0,0,0,0, 0,0,0,1,32'hC2C2C2C2, 2)};
        tbl[23] = '{ii(1,0,32'h300,0, 0,0,0, 1,1,32'hC3C3C3C3), oo(2'b10,0,0,0,0, 0,0,0,1,32'hC3C3C3C3, 1)};
        tbl[24] = '{ii(1,0,32'h300,0, 0,0,0, 1,0,0), zo()};
        tbl[25] = '{ii(1,0,32'h300,0, 0,0,0, 1,0,0), oo(2'b01,1,0,32'h300,0, 1,0,0,0,0, 0)};
        tbl[26] = '{idle_in(1,32'hD4D4D4D4),         oo(2'b01,0,0,0,0, 0,1,0,0,32'hD4D4D4D4, 1)};
        tbl[27] = '{idle_in(1,32'hEEEEEEEE),         zo()};
        tbl[28] = '{ii(1,1,32'h50,32'h12345678, 0,0,0, 1,0,0), zo()};
        tbl[29] = '{ii(1,1,32'h50,32'h12345678, 0,1,32'h999, 1,0,0), oo(2'b01,0,1,32'h50,32'h12345678, 1,0,0,0,0, 0)};
        tbl[30] = '{idle_in(0,0),                    oo(2'b01,0,0,0,0, 0,0,0,0,0, 0)};
        tbl[31] = '{idle_in(0,0),                    zo()};

        drive(idle_in(0, 32'h0));
        apply("reset_idle", idle_in(0, 32'h0), zo());
        apply("reset_req", ii(1,0,32'h100,0, 1,1,32'h200, 1,1,32'h55), zo());
        drive(idle_in(0, 32'h0));
        rst_n = 1'b1;

        for (int k = 0; k < 32; k++) apply($sformatf("row%0d", k), tbl[k].i, tbl[k].o);

        // Two back-to-back ties from reset.
        do_reset();
        apply("tie1_idle", ii(1,0,32'h100,0, 1,0,32'h200, 1,0,0), zo());
        apply("tie1_grant", ii(1,0,32'h100,0, 1,0,32'h200, 1,0,0),
              oo(2'b10,1,0,32'h200,0, 0,0,1,0,0, 0));
        apply("tie1_ret", ii(1,0,32'h100,0, 0,0,0, 1,1,32'h77),
              oo(2'b10,0,0,0,0, 0,0,0,1,32'h77, 1));
        apply("tie2_idle", ii(1,0,32'h100,0, 1,0,32'h200, 1,0,0), zo());
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        apply("tie2_grant", ii(1,0,32'h100,0, 1,0,32'h200, 1,0,0),
              oo(2'b10,1,0,32'h200,0, 0,0,1,0,0, 0));
        apply("tie2_ret", idle_in(1, 32'h88), oo(2'b10,0,0,0,0, 0,0,0,1,32'h88, 1));
`else
        apply("tie2_grant", ii(1,0,32'h100,0, 1,0,32'h200, 1,0,0),
              oo(2'b01,1,0,32'h100,0, 1,0,0,0,0, 0));
        apply("tie2_ret", idle_in(1, 32'h88), oo(2'b01,0,0,0,0, 0,1,0,0,32'h88, 1));
`endif
        apply("tie_end", idle_in(0, 32'h0), zo());

        // Reset with three reads outstanding; late returns must be dropped.
        do_reset();
        apply("rb_idle", ii(1,0,32'h400,0, 0,0,0, 1,0,0), zo());
        apply("rb_rd0", ii(1,0,32'h400,0, 0,0,0, 1,0,0), oo(2'b01,1,0,32'h400,0, 1,0,0,0,0, 0));
        apply("rb_rd1", ii(1,0,32'h404,0, 0,0,0, 1,0,0), oo(2'b01,1,0,32'h404,0, 1,0,0,0,0, 1));
        apply("rb_rd2", ii(1,0,32'h408,0, 0,0,0, 1,0,0), oo(2'b01,1,0,32'h408,0, 1,0,0,0,0, 2));
        @(negedge clk);
        drive(ii(1,0,32'h40C,0, 0,0,0, 1,0,0));
        #1;
        rst_n = 1'b0;
        #1;
        check("rb_in_reset", zo());
        @(negedge clk);
        drive(idle_in(0, 32'h0));
        rst_n = 1'b1;
        apply("rb_late0", idle_in(1, 32'h99999999), zo());
        apply("rb_late1", idle_in(1, 32'h9A9A9A9A), zo());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
